// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-port DataMemory arbiter.
package dmem_arb_pkg;
   localparam int NPORT = 2;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } arb_state_t;

   typedef logic port_id_t;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: the port that did not win last time gets priority.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic [NPORT-1:0] valid,
   input  port_id_t         last,
   output port_id_t         grant,
   output logic             grant_valid
);

   always_comb begin
      grant_valid = |valid;
      if (&valid) begin
         grant = ~last;
      end else begin
         grant = valid[1];
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port DataMemory between core (port 0)
// and debug/loader (port 1); one outstanding transaction, registered response.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NPORT-1:0]             req_valid,
   output logic [NPORT-1:0]             req_ready,
   input  logic [NPORT-1:0]             req_we,
   input  logic [NPORT-1:0][DATA_W-1:0] req_addr,
   input  logic [NPORT-1:0][DATA_W-1:0] req_wdata,
   output logic [NPORT-1:0]             rsp_valid,
   input  logic [NPORT-1:0]             rsp_ready,
   output logic [DATA_W-1:0]            rsp_rdata,
   output logic                         rsp_err,
   output logic                         mem_we,
   output logic [DATA_W-1:0]            mem_addr,
   output logic [DATA_W-1:0]            mem_wdata,
   input  logic [DATA_W-1:0]            mem_rdata
);

   localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);

   arb_state_t        state_reg, state_next;
   port_id_t          last_grant_reg;
   port_id_t          owner_reg;
   logic [NPORT-1:0]  rsp_valid_reg;
   logic [DATA_W-1:0] rsp_rdata_reg;
   logic              rsp_err_reg;

   port_id_t          grant;
   logic              grant_valid;
   logic              grant_en;
   logic              accept;
   logic              rsp_done;
   logic              in_range;
   logic [DATA_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_we;

   rr_arb2 u_rr_arb2 (
      .valid       (req_valid),
      .last        (last_grant_reg),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   assign sel_addr  = req_addr[grant];
   assign sel_wdata = req_wdata[grant];
   assign sel_we    = req_we[grant];
   // Full-width compare: huge addresses must not alias into the memory.
   assign in_range  = (sel_addr < DEPTH_W);

   // A request seen during reset is never accepted, so no write can slip through.
   assign grant_en  = (state_reg == IDLE) && grant_valid && !reset;
   assign accept    = grant_en;
   assign rsp_done  = (state_reg == RESP) && rsp_ready[owner_reg];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept)   state_next = RESP;
         RESP:    if (rsp_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   generate
      for (genvar gi = 0; gi < NPORT; gi++) begin : g_ready
         assign req_ready[gi] = grant_en && (grant == port_id_t'(gi));
      end
   endgenerate

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (grant_en) begin
         mem_we    = sel_we && in_range;
         mem_addr  = sel_addr;
         mem_wdata = sel_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_reg <= 1'b1;
         owner_reg      <= 1'b0;
         rsp_valid_reg  <= '0;
         rsp_rdata_reg  <= '0;
         rsp_err_reg    <= 1'b0;
      end else if (accept) begin
         last_grant_reg <= grant;
         owner_reg      <= grant;
         rsp_valid_reg  <= (grant == 1'b1) ? 2'b10 : 2'b01;
         rsp_rdata_reg  <= (!sel_we && in_range) ? mem_rdata : '0;
         rsp_err_reg    <= !in_range;
      end else if (rsp_done) begin
         rsp_valid_reg  <= '0;
      end
   end

   assign rsp_valid = rsp_valid_reg;
   assign rsp_rdata = rsp_rdata_reg;
   assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory behind the DUT, a transaction-level reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_dmem_arbiter;

   localparam int DW  = 64;
   localparam int DEP = 32;

   logic               clk = 1'b0;
   logic               reset;
   logic [1:0]         req_valid;
   logic [1:0]         req_ready;
   logic [1:0]         req_we;
   logic [1:0][DW-1:0] req_addr;
   logic [1:0][DW-1:0] req_wdata;
   logic [1:0]         rsp_valid;
   logic [1:0]         rsp_ready;
   logic [DW-1:0]      rsp_rdata;
   logic               rsp_err;
   logic               mem_we;
   logic [DW-1:0]      mem_addr;
   logic [DW-1:0]      mem_wdata;
   logic [DW-1:0]      mem_rdata;

   int total = 0;
   int bad   = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   dmem_arbiter #(.DATA_W(DW), .DEPTH(DEP)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   function automatic logic [DW-1:0] init_val(input logic [DW-1:0] a);
      return 64'h1000 + a;
   endfunction

   // Memory seen by the DUT: unwritten words read back their init pattern.
   logic [DEP-1:0] dm_wr = '0;
   logic [DW-1:0]  dm_val [DEP];
   always @(posedge clk) begin
      if (mem_we && mem_addr < DEP) begin
         dm_wr[mem_addr[4:0]]  <= 1'b1;
         dm_val[mem_addr[4:0]] <= mem_wdata;
      end
   end
   assign mem_rdata = (mem_addr >= DEP) ? '0 :
                      (dm_wr[mem_addr[4:0]] ? dm_val[mem_addr[4:0]] : init_val(mem_addr));

   // Reference model: memory contents plus the single pending response.
   logic [DEP-1:0] rm_wr = '0;
   logic [DW-1:0]  rm_val [DEP];
   logic           m_busy  = 1'b0;
   logic           m_owner = 1'b0;
   logic           m_last  = 1'b1;
   logic [DW-1:0]  m_rdata = '0;
   logic           m_err   = 1'b0;
   logic           m_any, m_g, m_in, m_acc;
   logic [DW-1:0]  m_a, m_rd;

   always_comb begin
      m_any = |req_valid;
      m_g   = (&req_valid) ? ~m_last : req_valid[1];
      m_a   = req_addr[m_g];
      m_in  = (m_a < DEP);
      m_acc = !reset && !m_busy && m_any;
      m_rd  = !m_in ? '0 : (rm_wr[m_a[4:0]] ? rm_val[m_a[4:0]] : init_val(m_a));
   end

   always @(posedge clk) begin
      if (reset) begin
         m_busy  <= 1'b0;
         m_last  <= 1'b1;
         m_rdata <= '0;
         m_err   <= 1'b0;
      end else if (m_acc) begin
         if (req_we[m_g] && m_in) begin
            rm_wr[m_a[4:0]]  <= 1'b1;
            rm_val[m_a[4:0]] <= req_wdata[m_g];
         end
         m_rdata <= (!req_we[m_g] && m_in) ? m_rd : '0;
         m_err   <= !m_in;
         m_busy  <= 1'b1;
         m_owner <= m_g;
         m_last  <= m_g;
      end else if (m_busy && rsp_ready[m_owner]) begin
         m_busy <= 1'b0;
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, mid-cycle when inputs are stable.
   always @(negedge clk) begin
      if (started) begin
         logic [1:0] e_ready;
         logic       e_we;
         e_ready = m_acc ? (m_g ? 2'b10 : 2'b01) : 2'b00;
         e_we    = m_acc && req_we[m_g] && m_in;
         chk("m_req_ready", DW'(req_ready), DW'(e_ready));
         chk("m_mem_we", DW'(mem_we), DW'(e_we));
         chk("m_rsp_valid", DW'(rsp_valid), m_busy ? (m_owner ? 64'd2 : 64'd1) : 64'd0);
         chk("m_rsp_rdata", rsp_rdata, m_rdata);
         chk("m_rsp_err", DW'(rsp_err), DW'(m_err));
         if (e_we) begin
            chk("m_mem_addr", mem_addr, m_a);
            chk("m_mem_wdata", mem_wdata, req_wdata[m_g]);
         end
      end
   end

   // One request on one port, then check the response one cycle after accept.
   task automatic single(input int p, input logic we, input logic [DW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] e_rd,
                         input logic e_err, input string name);
      int n;
      @(posedge clk); #1;
      req_valid[p] = 1'b1;
      req_we[p]    = we;
      req_addr[p]  = a;
      req_wdata[p] = wd;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready[p] && n < 20);
      if (!req_ready[p]) begin
         total++;
         bad++;
         $display("FAIL %s_accept_timeout actual=no_ready required=ready", name);
      end
      @(posedge clk); #1;
      req_valid[p] = 1'b0;
      @(negedge clk);
      chk({name, "_valid"}, DW'(rsp_valid[p]), 64'd1);
      chk({name, "_rdata"}, rsp_rdata, e_rd);
      chk({name, "_err"}, DW'(rsp_err), DW'(e_err));
      $display("txn %s port=%0d we=%0d addr=%h rdata=%h err=%0d", name, p, we, a, rsp_rdata, rsp_err);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] grants [$];
      reset     = 1'b1;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 2'b11;
      @(posedge clk);
      started = 1'b1;
      @(negedge clk);
      chk("rst_rsp_valid", DW'(rsp_valid), 64'd0);
      chk("rst_rsp_rdata", rsp_rdata, 64'd0);
      chk("rst_rsp_err", DW'(rsp_err), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Write then read back on port 0.
      single(0, 1'b1, 64'd3, 64'hDEADBEEF, 64'd0, 1'b0, "wr3");
      single(0, 1'b0, 64'd3, 64'd0, 64'hDEADBEEF, 1'b0, "rd3");

      // Out-of-range and boundary addresses.
      single(1, 1'b1, 64'd32, 64'h55, 64'd0, 1'b1, "wr32");
      single(1, 1'b0, 64'd0, 64'd0, 64'h1000, 1'b0, "rd0");
      single(0, 1'b1, 64'd31, 64'hABC, 64'd0, 1'b0, "wr31");
      single(1, 1'b0, 64'd31, 64'd0, 64'hABC, 1'b0, "rd31");
      single(0, 1'b0, 64'h1_0000_0003, 64'd0, 64'd0, 1'b1, "rdwide");

      // Fairness from reset with both ports continuously valid.
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset       = 1'b0;
      req_valid   = 2'b11;
      req_we      = 2'b00;
      req_addr[0] = 64'd1;
      req_addr[1] = 64'd2;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (req_ready != 2'b00) grants.push_back(req_ready);
         if (rsp_valid == 2'b01) chk("rr_rdata0", rsp_rdata, 64'h1001);
         if (rsp_valid == 2'b10) chk("rr_rdata1", rsp_rdata, 64'h1002);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      chk("rr_count", DW'(grants.size()), 64'd6);
      for (int k = 0; k < grants.size(); k++) begin
         chk("rr_order", DW'(grants[k]), (k % 2 == 0) ? 64'd1 : 64'd2);
         $display("txn rr grant#%0d req_ready=%b", k, grants[k]);
      end
      @(posedge clk);

      // Response backpressure on port 0 while port 1 waits.
      @(posedge clk); #1;
      rsp_ready   = 2'b10;
      req_valid   = 2'b01;
      req_addr[0] = 64'd3;
      req_addr[1] = 64'd2;
      @(negedge clk);
      chk("bp_accept", DW'(req_ready), 64'd1);
      @(posedge clk); #1;
      req_valid = 2'b10;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_valid", DW'(rsp_valid), 64'd1);
         chk("bp_rdata", rsp_rdata, 64'hDEADBEEF);
         chk("bp_ready", DW'(req_ready), 64'd0);
         if (c < 4) @(posedge clk);
      end
      @(posedge clk); #1;
      rsp_ready = 2'b11;
      @(negedge clk);
      chk("bp_hold_last", DW'(rsp_valid), 64'd1);
      @(negedge clk);
      chk("bp_idle_valid", DW'(rsp_valid), 64'd0);
      chk("bp_idle_grant1", DW'(req_ready), 64'd2);
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      chk("bp_p1_rdata", rsp_rdata, 64'h1002);
      $display("txn bp port=1 rdata=%h", rsp_rdata);
      @(posedge clk);

      // Reset while holding a response.
      @(posedge clk); #1;
      rsp_ready   = 2'b01;
      req_valid   = 2'b10;
      req_addr[1] = 64'd2;
      @(negedge clk);
      chk("rr5_accept", DW'(req_ready), 64'd2);
      @(posedge clk); #1;
      req_valid   = 2'b11;
      req_addr[0] = 64'd1;
      reset       = 1'b1;
      @(negedge clk);
      chk("rr5_resp_held", DW'(rsp_valid), 64'd2);
      chk("rr5_no_ready_in_reset", DW'(req_ready), 64'd0);
      @(posedge clk); #1;
      reset     = 1'b0;
      rsp_ready = 2'b11;
      @(negedge clk);
      chk("rr5_dropped", DW'(rsp_valid), 64'd0);
      chk("rr5_port0_first", DW'(req_ready), 64'd1);
      $display("txn reset_in_resp rsp_valid=%b req_ready=%b", rsp_valid, req_ready);
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(posedge clk);

      // Reset coinciding with a write request.
      @(posedge clk); #1;
      reset        = 1'b1;
      req_valid    = 2'b01;
      req_we       = 2'b01;
      req_addr[0]  = 64'd5;
      req_wdata[0] = 64'h777;
      @(negedge clk);
      chk("rw_mem_we", DW'(mem_we), 64'd0);
      @(posedge clk); #1;
      reset     = 1'b0;
      req_valid = 2'b00;
      req_we    = 2'b00;
      single(0, 1'b0, 64'd5, 64'd0, 64'h1005, 1'b0, "rd5");

      @(posedge clk);
      @(posedge clk);
      for (int i = 0; i < DEP; i++) begin
         chk("final_mem", dm_wr[i] ? dm_val[i] : init_val(DW'(i)),
                          rm_wr[i] ? rm_val[i] : init_val(DW'(i)));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
